// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the RAM-backed calculator sequencer.
package calc_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, CAP_B, START, WAIT, WR_Y, WR_ST, HOLD, END
  } seq_state_t;

  localparam int OFF_A  = 0;
  localparam int OFF_B  = 1;
  localparam int OFF_Y  = 2;
  localparam int OFF_ST = 3;

  // Status word: run count in the top byte, error/ok flags in the low bits.
  localparam int ST_OK_BIT  = 0;
  localparam int ST_ERR_BIT = 1;
  localparam int ST_CNT_W   = 8;

endpackage

// File: rtl/calc_timeout_cnt.sv
// Wait-cycle counter: synchronous clear, count enable, terminal count at TIMEOUT-1.
module calc_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == TC_VAL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/calc_ram_sequencer.sv
// Reads A/B from RAM, runs the calculator with a timeout, writes Y and a status word.
module calc_ram_sequencer
  import calc_seq_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] BASE    = '0,
  parameter int                TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              contr_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] calc_a_o,
  output logic [DATA_W-1:0] calc_b_o,
  output logic              calc_start_o,
  input  logic              calc_fim_i,
  input  logic [DATA_W-1:0] calc_y_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output seq_state_t        state_o
);

  seq_state_t    state;
  logic [DATA_W-1:0] op_a, op_b, y_q;
  logic [ST_CNT_W-1:0] run_cnt;
  logic          tmo_tc;

  function automatic logic [DATA_W-1:0] status_word(input logic [ST_CNT_W-1:0] cnt,
                                                    input logic e);
    logic [DATA_W-1:0] w;
    w = '0;
    w[DATA_W-1 -: ST_CNT_W] = cnt;
    w[ST_ERR_BIT]           = e;
    w[ST_OK_BIT]            = ~e;
    return w;
  endfunction

  calc_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (state == START),
    .en    (state == WAIT),
    .tc    (tmo_tc)
  );

  assign calc_a_o = op_a;
  assign calc_b_o = op_b;
  assign state_o  = state;

  // Outputs are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ram_addr_o   <= BASE;
      ram_we_o     <= 1'b0;
      ram_wdata_o  <= '0;
      calc_start_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      y_q          <= '0;
      run_cnt      <= '0;
    end else begin
      ram_we_o     <= 1'b0;
      calc_start_o <= 1'b0;
      case (state)
        IDLE: if (contr_i) begin
          state      <= RD_A;
          ram_addr_o <= BASE + ADDR_W'(OFF_A);
          busy_o     <= 1'b1;
        end
        RD_A: begin
          state      <= RD_B;
          ram_addr_o <= BASE + ADDR_W'(OFF_B);
        end
        RD_B: begin
          op_a  <= ram_rdata_i;
          state <= CAP_B;
        end
        CAP_B: begin
          op_b         <= ram_rdata_i;
          calc_start_o <= 1'b1;
          state        <= START;
        end
        START: state <= WAIT;
        WAIT: begin
          // A done flag on the terminal wait cycle still counts as success.
          if (calc_fim_i) begin
            y_q         <= calc_y_i;
            err_o       <= 1'b0;
            ram_we_o    <= 1'b1;
            ram_addr_o  <= BASE + ADDR_W'(OFF_Y);
            ram_wdata_o <= calc_y_i;
            state       <= WR_Y;
          end else if (tmo_tc) begin
            err_o       <= 1'b1;
            ram_we_o    <= 1'b1;
            ram_addr_o  <= BASE + ADDR_W'(OFF_ST);
            ram_wdata_o <= status_word(run_cnt, 1'b1);
            state       <= WR_ST;
          end
        end
        WR_Y: begin
          ram_we_o    <= 1'b1;
          ram_addr_o  <= BASE + ADDR_W'(OFF_ST);
          ram_wdata_o <= status_word(run_cnt, err_o);
          state       <= WR_ST;
        end
        WR_ST: begin
          run_cnt <= run_cnt + 1'b1;
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          state   <= HOLD;
        end
        HOLD: if (!contr_i) begin
          done_o <= 1'b0;
          state  <= END;
        end
        END:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
